// File: rtl/aes_inv_cipher.sv
`default_nettype none
// ============================================================================
// Module   : aes_inv_cipher
// Purpose  : Iterative AES-128 inverse cipher, one round per clock. Round keys
//            are fetched externally through rk_idx/rk_data.
// Revision : 1.0 - initial release
// ============================================================================
module aes_inv_cipher (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Ascending packed range: element 0 sits in the leftmost byte of the literal.
    localparam logic [0:255][7:0] c_inv_sbox = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] a);
        return xt(xt(xt(a))) ^ a;
    endfunction

    function automatic logic [7:0] mulb(input logic [7:0] a);
        return xt(xt(xt(a))) ^ xt(a) ^ a;
    endfunction

    function automatic logic [7:0] muld(input logic [7:0] a);
        return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
    endfunction

    function automatic logic [7:0] mule(input logic [7:0] a);
        return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
    endfunction

    state_t       st_q, st_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] s_q, s_d;

    logic [7:0]   w_s_b   [16];
    logic [7:0]   w_rk_b  [16];
    logic [7:0]   w_isr_b [16];
    logic [7:0]   w_ark_b [16];
    logic [127:0] w_ark;
    logic [127:0] w_imc;

    // Row-major bytes: row r rotates right by r, so out[4r+c] = in[4r+(c-r)%4].
    for (genvar i = 0; i < 16; i++) begin : g_bytes
        assign w_s_b[i]   = s_q[127-8*i -: 8];
        assign w_rk_b[i]  = rk_data[127-8*i -: 8];
        assign w_isr_b[i] = w_s_b[4*(i/4) + (((i%4) - (i/4) + 4) % 4)];
        assign w_ark_b[i] = c_inv_sbox[w_isr_b[i]] ^ w_rk_b[i];
        assign w_ark[127-8*i -: 8] = w_ark_b[i];
    end

    for (genvar c = 0; c < 4; c++) begin : g_cols
        logic [7:0] a0, a1, a2, a3;
        assign a0 = w_ark_b[c];
        assign a1 = w_ark_b[4+c];
        assign a2 = w_ark_b[8+c];
        assign a3 = w_ark_b[12+c];
        assign w_imc[127-8*c -: 8]      = mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3);
        assign w_imc[127-8*(4+c) -: 8]  = mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3);
        assign w_imc[127-8*(8+c) -: 8]  = muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3);
        assign w_imc[127-8*(12+c) -: 8] = mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q  <= IDLE;
            cnt_q <= 4'd0;
            s_q   <= 128'd0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            s_q   <= s_d;
        end
    end

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        s_d    = s_q;
        rk_idx = 4'd0;
        case (st_q)
            IDLE: begin
                rk_idx = 4'd10;
                if (in_valid && in_ready) begin
                    s_d   = data_in ^ rk_data;
                    cnt_d = 4'd9;
                    st_d  = ROUND;
                end
            end
            ROUND: begin
                rk_idx = cnt_q;
                s_d    = w_imc;
                cnt_d  = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    st_d = FINAL;
                end
            end
            FINAL: begin
                s_d  = w_ark;
                st_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    st_d = IDLE;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    // in_ready is qualified by rst so it drops the instant reset is applied.
    assign in_ready  = (st_q == IDLE) && !rst;
    assign out_valid = (st_q == DONE);
    assign busy      = (st_q != IDLE);
    assign data_out  = (st_q == DONE) ? s_q : 128'd0;

endmodule
`default_nettype wire

// File: doc/aes_inv_cipher.md
AES_INV_CIPHER -- requirements
Module: aes_inv_cipher

Interface
REQ-001 Parameters: none; block is AES-128 only, 10 rounds fixed.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset: clk and rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  1  ciphertext present on data_in.
REQ-006 in_ready  output  1  block can accept ciphertext; high only in IDLE and rst low.
REQ-007 data_in  input  128  ciphertext state, row-major: byte i = bits [127-8i -: 8], row r = bytes 4r..4r+3, column c = bytes c, 4+c, 8+c, 12+c.
REQ-008 rk_idx  output  4  index (0..10) of the round key required this cycle.
REQ-009 rk_data  input  128  round key rk_idx, same row-major layout, valid combinationally in the same cycle.
REQ-010 out_valid  output  1  plaintext present on data_out.
REQ-011 out_ready  input  1  consumer accepts data_out.
REQ-012 data_out  output  128  plaintext state, row-major layout.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states SHALL be IDLE, ROUND, FINAL, DONE; 4-bit round counter cnt.
REQ-015 rk_idx SHALL be 10 in IDLE, cnt in ROUND, 0 in FINAL, 0 in DONE.
REQ-016 IDLE: on in_valid&in_ready the state register SHALL load data_in XOR rk_data (rk10), cnt<=9, go ROUND; otherwise stay.
REQ-017 ROUND, one cycle per round: s <= InvMixColumns(InvSubBytes(InvShiftRows(s)) XOR rk_data); cnt decrements; after cnt==1 go FINAL.
REQ-018 FINAL: s <= InvSubBytes(InvShiftRows(s)) XOR rk_data (rk0); go DONE.
REQ-019 InvShiftRows SHALL rotate row r right by r bytes (out row1 = b7,b4,b5,b6; row2 = b10,b11,b8,b9; row3 = b13,b14,b15,b12).
REQ-020 InvSubBytes SHALL apply the FIPS-197 inverse S-box to all 16 bytes in parallel.
REQ-021 InvMixColumns SHALL multiply each column by {0e,0b,0d,09} circulant in GF(2^8) modulo x^8+x^4+x^3+x+1.
REQ-022 Latency: ciphertext accepted at edge N SHALL produce out_valid=1 after edge N+10.
REQ-023 DONE: out_valid=1, data_out=s held stable until out_valid&out_ready; then go IDLE on that edge.
REQ-024 No new ciphertext SHALL be accepted in the cycle that the result is consumed; in_ready rises the following cycle.
REQ-025 in_valid while busy SHALL be ignored, with no state change.
REQ-026 out_ready is ignored outside DONE.

Reset
REQ-027 rst high SHALL immediately force IDLE, cnt=0, state register=0, out_valid=0, data_out=0, busy=0, in_ready=0, rk_idx=10.
REQ-028 Reset asserted mid-operation SHALL discard the block with no partial output; after deassert in_ready=1 on the next cycle.

Verification
REQ-029 FIPS-197 C.1 key schedule transposed to row-major; data_in=696ad870c47bcdb4e004b7c5d830805a -> data_out=004488cc115599dd2266aaee3377bbff, out_valid exactly after edge N+10.
REQ-030 Sample rk_idx each cycle of the same run -> sequence 10,9,8,...,1,0.
REQ-031 Hold out_ready=0 for 5 cycles in DONE -> data_out constant, out_valid=1, in_ready=0; assert out_ready -> IDLE next edge, then in_ready=1.
REQ-032 Pulse in_valid with a different data_in during ROUND -> ignored; C.1 result unchanged.
REQ-033 Assert rst at the round with cnt==5 -> all outputs at reset values immediately; rerun C.1 -> correct plaintext.
REQ-034 Two back-to-back C.1 blocks with out_ready tied 1 -> both correct; second accept no earlier than 1 cycle after the first output handshake.
